// File: rtl/enoc_packet_sink_pkg.sv
// enoc_packet_sink_pkg: ENoC mesh config, packet format, LFSR constants and sink state codes.
package enoc_packet_sink_pkg;
   localparam int NOC_X = 4;
   localparam int NOC_Y = 4;
   localparam int NOC_NODES = NOC_X * NOC_Y;
   localparam int SRC_W = $clog2(NOC_NODES);
   localparam int DATA_W = 16;
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [SRC_W-1:0]  source;
      logic [SRC_W-1:0]  dest;
      logic              valid;
   } packet_t;
   // Galois form of the x^16 + x^14 + x^13 + x^11 + 1 polynomial
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_DONE = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return &v ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/enoc_lfsr16.sv
// enoc_lfsr16: free-running 16-bit Galois LFSR; a zero seed is forced to 1 so the register never locks up.
module enoc_lfsr16
   import enoc_packet_sink_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        advance_i,
   output logic [15:0] state_o
);
   localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
   logic [15:0] state_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state_q <= INIT;
      else if (advance_i) state_q <= lfsr_step(state_q);
   assign state_o = state_q;
endmodule

// File: rtl/enoc_packet_sink.sv
// enoc_packet_sink: local-port consumer with random backpressure, dest and per-source sequence checking,
// saturating traffic counters and sticky done/error flags.
module enoc_packet_sink
   import enoc_packet_sink_pkg::*;
#(
   parameter int          X_NODES       = NOC_X,
   parameter int          Y_NODES       = NOC_Y,
   parameter int          X_LOC         = 1,
   parameter int          Y_LOC         = 1,
   parameter int          EXPECTED_PKTS = 20,
   parameter int          EN_THRESHOLD  = 128,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter bit          HALT_ON_ERROR = 1'b0
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  packet_t                              i_data,
   input  logic                                 i_data_val,
   output logic                                 o_en,
   output logic [15:0]                          o_rx_count,
   output logic [15:0]                          o_seq_err_count,
   output logic [15:0]                          o_dest_err_count,
   output logic [$clog2(X_NODES*Y_NODES)-1:0]   o_last_source,
   output logic                                 o_done,
   output logic                                 o_error
);
   localparam int NODES = X_NODES * Y_NODES;
   localparam int LS_W = $clog2(NODES);
   localparam logic [SRC_W-1:0] NODE_ID = SRC_W'(Y_LOC * X_NODES + X_LOC);
   localparam logic [8:0] THR = 9'(EN_THRESHOLD);
   localparam logic [15:0] EXP_N = 16'(EXPECTED_PKTS);
   logic [15:0] lfsr, lfsr_nx;
   logic en_q, done_q, err_q;
   logic [15:0] rx_q, rx_d, seq_q, dest_q;
   logic [LS_W-1:0] last_q;
   logic [1:0] state_q, state_d;
   logic [DATA_W-1:0] exp_q [NODES];
   logic xfer, src_ok, seq_e, dest_e, any_e, complete, in_done;
   enoc_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk       (clk),
      .reset_n   (reset_n),
      .advance_i (1'b1),
      .state_o   (lfsr)
   );
   assign lfsr_nx = lfsr_step(lfsr);
   assign xfer = i_data_val & en_q;
   assign in_done = state_q == S_DONE;
   assign src_ok = int'(i_data.source) < NODES;
   // Once DONE every further packet is an overrun and is not charged to the seq/dest counters
   assign seq_e = xfer & ~in_done & ~(src_ok && i_data.data == exp_q[i_data.source]);
   assign dest_e = xfer & ~in_done & (i_data.dest != NODE_ID);
   assign any_e = seq_e | dest_e | (xfer & in_done);
   assign rx_d = xfer ? sat_inc(rx_q) : rx_q;
   assign complete = xfer & (state_q == S_RUN) & (rx_d == EXP_N);
   assign state_d = (state_q == S_HALT || (any_e && HALT_ON_ERROR)) ? S_HALT :
                    complete ? S_DONE : state_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         en_q    <= 1'b0;
         rx_q    <= '0;
         seq_q   <= '0;
         dest_q  <= '0;
         last_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         state_q <= S_RUN;
         for (int i = 0; i < NODES; i++) exp_q[i] <= DATA_W'(1);
      end else begin
         en_q    <= (state_d != S_HALT) && ({1'b0, lfsr_nx[7:0]} < THR);
         rx_q    <= rx_d;
         seq_q   <= seq_e ? sat_inc(seq_q) : seq_q;
         dest_q  <= dest_e ? sat_inc(dest_q) : dest_q;
         last_q  <= xfer ? LS_W'(i_data.source) : last_q;
         done_q  <= done_q | complete;
         err_q   <= err_q | any_e;
         state_q <= state_d;
         if (xfer && src_ok) exp_q[i_data.source] <= i_data.data + DATA_W'(1);
      end
   assign o_en = en_q;
   assign o_rx_count = rx_q;
   assign o_seq_err_count = seq_q;
   assign o_dest_err_count = dest_q;
   assign o_last_source = last_q;
   assign o_done = done_q;
   assign o_error = err_q;
endmodule

// File: tb/tb_enoc_packet_sink.sv
// tb_enoc_packet_sink: directed checks of the packet sink across several parameterisations sharing one stimulus.
module tb_enoc_packet_sink;
   import enoc_packet_sink_pkg::*;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   packet_t pkt = '0;
   logic val = 1'b0;
   int checks = 0;
   int passes = 0;
   logic en_a, dn_a, er_a, en_b, dn_b, er_b, en_c, dn_c, er_c, en_d, dn_d, er_d, en_e, dn_e, er_e;
   logic [15:0] rx_a, se_a, de_a, rx_b, se_b, de_b, rx_c, se_c, de_c, rx_d, se_d, de_d, rx_e, se_e, de_e;
   logic [3:0] ls_a, ls_b, ls_c, ls_d, ls_e;
   always #5 clk = ~clk;
   enoc_packet_sink #(.EN_THRESHOLD(256)) u_a (
      .clk(clk), .reset_n(reset_n), .i_data(pkt), .i_data_val(val), .o_en(en_a), .o_rx_count(rx_a),
      .o_seq_err_count(se_a), .o_dest_err_count(de_a), .o_last_source(ls_a), .o_done(dn_a), .o_error(er_a));
   enoc_packet_sink #(.EN_THRESHOLD(256), .HALT_ON_ERROR(1'b1)) u_b (
      .clk(clk), .reset_n(reset_n), .i_data(pkt), .i_data_val(val), .o_en(en_b), .o_rx_count(rx_b),
      .o_seq_err_count(se_b), .o_dest_err_count(de_b), .o_last_source(ls_b), .o_done(dn_b), .o_error(er_b));
   enoc_packet_sink #(.EN_THRESHOLD(0)) u_c (
      .clk(clk), .reset_n(reset_n), .i_data(pkt), .i_data_val(val), .o_en(en_c), .o_rx_count(rx_c),
      .o_seq_err_count(se_c), .o_dest_err_count(de_c), .o_last_source(ls_c), .o_done(dn_c), .o_error(er_c));
   enoc_packet_sink #(.EN_THRESHOLD(128)) u_d (
      .clk(clk), .reset_n(reset_n), .i_data(pkt), .i_data_val(val), .o_en(en_d), .o_rx_count(rx_d),
      .o_seq_err_count(se_d), .o_dest_err_count(de_d), .o_last_source(ls_d), .o_done(dn_d), .o_error(er_d));
   enoc_packet_sink #(.EN_THRESHOLD(256), .EXPECTED_PKTS(2)) u_e (
      .clk(clk), .reset_n(reset_n), .i_data(pkt), .i_data_val(val), .o_en(en_e), .o_rx_count(rx_e),
      .o_seq_err_count(se_e), .o_dest_err_count(de_e), .o_last_source(ls_e), .o_done(dn_e), .o_error(er_e));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
   endtask
   task automatic do_reset();
      @(negedge clk);
      val = 1'b0;
      pkt = '0;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask
   task automatic send(input logic [3:0] src, input logic [3:0] dst, input logic [15:0] d);
      @(negedge clk);
      pkt.data = d;
      pkt.source = src;
      pkt.dest = dst;
      pkt.valid = 1'b1;
      val = 1'b1;
      @(negedge clk);
      val = 1'b0;
   endtask
   initial begin
      int ones;
      logic seen;
      @(negedge clk);
      chk("reset_en", en_a, 0);
      chk("reset_rx", rx_a, 0);
      chk("reset_flags", {dn_a, er_a}, 0);
      do_reset();
      chk("en_after_release", en_a, 1);
      for (int i = 1; i <= 19; i++) send(4'd5, 4'd5, 16'(i));
      chk("t1_not_done_19", dn_a, 0);
      send(4'd5, 4'd5, 16'd20);
      chk("t1_rx", rx_a, 20);
      chk("t1_done", dn_a, 1);
      chk("t1_seq", se_a, 0);
      chk("t1_dest", de_a, 0);
      chk("t1_error", er_a, 0);
      chk("t1_last_src", ls_a, 5);
      do_reset();
      send(4'd3, 4'd5, 16'd1);
      send(4'd3, 4'd5, 16'd2);
      chk("t2_seq_clean", se_a, 0);
      send(4'd3, 4'd5, 16'd4);
      chk("t2_seq_gap", se_a, 1);
      chk("t2_error", er_a, 1);
      send(4'd3, 4'd5, 16'd5);
      chk("t2_resync", se_a, 1);
      chk("t2_rx", rx_a, 4);
      chk("t2_last_src", ls_a, 3);
      do_reset();
      send(4'd0, 4'd6, 16'd1);
      chk("t3_dest", de_b, 1);
      chk("t3_seq", se_b, 0);
      chk("t3_error", er_b, 1);
      chk("t3_en_nohalt", en_a, 1);
      chk("t3_dest_nohalt", de_a, 1);
      seen = 1'b0;
      val = 1'b1;
      pkt.dest = 4'd5;
      for (int i = 0; i < 50; i++) begin
         seen |= en_b;
         @(negedge clk);
      end
      val = 1'b0;
      chk("t3_halt_en", seen, 0);
      chk("t3_halt_rx", rx_b, 1);
      do_reset();
      seen = 1'b0;
      pkt.source = 4'd5;
      pkt.dest = 4'd5;
      val = 1'b1;
      for (int i = 0; i < 100; i++) begin
         seen |= en_c;
         @(negedge clk);
      end
      chk("t4_en_never", seen, 0);
      chk("t4_rx_zero", rx_c, 0);
      ones = 0;
      for (int i = 0; i < 1000; i++) begin
         ones += int'(en_d);
         @(negedge clk);
      end
      val = 1'b0;
      chk("t4_duty", (ones >= 400 && ones <= 600), 1);
      do_reset();
      send(4'd5, 4'd5, 16'd1);
      chk("t5_done_1", dn_e, 0);
      send(4'd5, 4'd5, 16'd2);
      chk("t5_done_2", dn_e, 1);
      chk("t5_err_2", er_e, 0);
      send(4'd5, 4'd5, 16'd3);
      chk("t5_err_3", er_e, 1);
      chk("t5_rx", rx_e, 3);
      chk("t5_seq_dest", {se_e, de_e}, 0);
      do_reset();
      for (int i = 1; i <= 7; i++) send(4'd5, 4'd5, 16'(i));
      chk("t6_rx7", rx_a, 7);
      @(negedge clk);
      pkt.data = 16'd8;
      val = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("t6_async_rx", rx_a, 0);
      chk("t6_async_en", en_a, 0);
      chk("t6_async_last", ls_a, 0);
      chk("t6_async_flags", {dn_a, er_a}, 0);
      val = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      send(4'd5, 4'd5, 16'd1);
      send(4'd5, 4'd5, 16'd2);
      chk("t6_restart_seq", se_a, 0);
      chk("t6_restart_rx", rx_a, 2);
      chk("t6_restart_err", er_a, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
